// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for an 8-digit, common-anode 7-segment display.
//   One hex nibble of a shadowed 32-bit word is shown per digit slot of
//   REFRESH_DIV clock cycles. The shadow is reloaded from to_display only at
//   the end of digit 7, so a frame never mixes two words.
//
// Ports
//   clock       in   1   system clock, rising edge
//   reset_n     in   1   asynchronous active-low reset
//   to_display  in  32   hex word, nibble i -> digit i (digit 0 rightmost)
//   blank_lz    in   1   1 = blank leading-zero digits (digit 0 never blanked)
//   dp_mask     in   8   bit i = 1 lights decimal point of digit i
//   an          out  8   anode enables, active-low
//   seg         out  7   {g,f,e,d,c,b,a}, active-low
//   dp          out  1   decimal point, active-low
//   frame_done  out  1   one-cycle pulse after the shadow word is reloaded
module seven_seg_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] to_display,
   input  logic        blank_lz,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned    PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic [31:0]   r_shadow;
   logic [7:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic          r_frame_done;

   logic          w_tick;
   logic          w_frame_end;
   logic [4:0]    w_bitpos;
   logic [31:0]   w_upper;
   logic [3:0]    w_nibble;
   logic          w_blank;
   logic [7:0]    w_an_onehot;
   logic [6:0]    w_seg;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      w_tick      = (r_presc == PRESC_MAX);
      w_frame_end = w_tick && (r_idx == 3'd7);
      w_bitpos    = {r_idx, 2'b00};
      w_nibble    = r_shadow[w_bitpos +: 4];
      // Everything from the current digit upward is zero -> leading zero.
      w_upper     = r_shadow >> w_bitpos;
      w_blank     = blank_lz && (r_idx != 3'd0) && (w_upper == '0);
      w_an_onehot = 8'b1 << r_idx;
      w_seg       = hex7(w_nibble);
   end

   // Scan state: prescaler, digit index and frame-synchronous shadow word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_presc  <= '0;
         r_idx    <= '0;
         r_shadow <= '0;
      end else begin
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         if (w_frame_end) begin
            r_shadow <= to_display;
         end
      end
   end

   // Output register: lags the scan state by one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_an         <= '1;
         r_seg        <= '1;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_blank) begin
            r_an  <= '1;
            r_seg <= '1;
            r_dp  <= 1'b1;
         end else begin
            r_an  <= ~w_an_onehot;
            r_seg <= w_seg;
            r_dp  <= ~dp_mask[r_idx];
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule
